digit_serial_adder: RTL and testbench

Digit-serial N-digit adder/subtractor for 4-bit digits in binary (radix 16) or BCD (radix 10) mode. Sits directly downstream of the BIN/BCD 1-complementer. Operand B arrives already complemented for subtraction, and this block injects the initial carry that turns the 9's/15's complement into a 10's/16's complement. Digits stream least-significant first, one per accepted cycle. The block returns a sum digit stream, the final carry and a done pulse.

---
 rtl/digit_pkg.sv | 18 +
 rtl/digit_serial_adder_if.sv | 33 +++
 rtl/bcd_digit_add.sv | 43 ++++
 rtl/digit_serial_adder.sv | 122 ++++++++++++
 tb/tb_digit_serial_adder.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/digit_pkg.sv
// Shared constants and types for the digit-serial adder/subtractor.
//   DIG_W   : digit width in bits
//   BCD_MAX : largest legal BCD digit
//   BCD_ADJ : decimal adjust added when a BCD digit sum exceeds BCD_MAX
//   state_e : control FSM states
package digit_pkg;

    localparam int unsigned DIG_W   = 4;
    localparam int unsigned BCD_MAX = 9;
    localparam int unsigned BCD_ADJ = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/digit_serial_adder_if.sv
// Digit-stream bundle between the operand source and the digit-serial adder.
//   start/bcd_mode/sub : operation request and mode, sampled with start
//   a_dig/b_dig/dig_valid : operand digit stream, least-significant first
//   busy : adder accepts digits
//   s_dig/s_valid : sum digit stream
//   carry_out/done/bcd_err : completion status
interface digit_serial_adder_if;
    import digit_pkg::*;

    logic             start;
    logic             bcd_mode;
    logic             sub;
    logic [DIG_W-1:0] a_dig;
    logic [DIG_W-1:0] b_dig;
    logic             dig_valid;
    logic             busy;
    logic [DIG_W-1:0] s_dig;
    logic             s_valid;
    logic             carry_out;
    logic             done;
    logic             bcd_err;

    modport master (
        output start, bcd_mode, sub, a_dig, b_dig, dig_valid,
        input  busy, s_dig, s_valid, carry_out, done, bcd_err
    );

    modport slave (
        input  start, bcd_mode, sub, a_dig, b_dig, dig_valid,
        output busy, s_dig, s_valid, carry_out, done, bcd_err
    );

endinterface

// File: rtl/bcd_digit_add.sv
// Combinational single-digit adder, radix 16 or radix 10.
//   a_i, b_i    : operand digits
//   c_in_i      : incoming carry
//   bcd_mode_i  : 1 = decimal-adjust the sum
//   s_c         : sum digit
//   c_out_c     : outgoing carry
//   err_c       : BCD mode and an operand digit above 9
module bcd_digit_add
    import digit_pkg::*;
(
    input  logic [DIG_W-1:0] a_i,
    input  logic [DIG_W-1:0] b_i,
    input  logic             c_in_i,
    input  logic             bcd_mode_i,
    output logic [DIG_W-1:0] s_c,
    output logic             c_out_c,
    output logic             err_c
);

    localparam int unsigned T_W = DIG_W + 1;

    logic [T_W-1:0]   t;
    logic [DIG_W-1:0] t_adj;

    // Low bits of t + 6 only depend on the low bits of t.
    assign t     = T_W'(a_i) + T_W'(b_i) + T_W'(c_in_i);
    assign t_adj = t[DIG_W-1:0] + DIG_W'(BCD_ADJ);

    always_comb begin
        s_c     = t[DIG_W-1:0];
        c_out_c = t[DIG_W];
        err_c   = bcd_mode_i && ((a_i > DIG_W'(BCD_MAX)) || (b_i > DIG_W'(BCD_MAX)));
        if (bcd_mode_i) begin
            if (t > T_W'(BCD_MAX)) begin
                s_c     = t_adj;
                c_out_c = 1'b1;
            end else begin
                c_out_c = 1'b0;
            end
        end
    end

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial NDIG-digit adder/subtractor, binary or BCD, LSD first.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of the digit stream bundle (see interface)
// For subtraction B arrives pre-complemented; seeding the carry with sub
// turns the 9's/15's complement into a 10's/16's complement.
module digit_serial_adder
    import digit_pkg::*;
#(
    parameter int unsigned NDIG = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    digit_serial_adder_if.slave  bus
);

    localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               bcd_q, bcd_d;
    logic [DIG_W-1:0]   s_dig_q, s_dig_d;
    logic               s_valid_q, s_valid_d;
    logic               carry_out_q, carry_out_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               bcd_err_q, bcd_err_d;

    logic [DIG_W-1:0]   sum_c;
    logic               c_out_c;
    logic               err_c;

    bcd_digit_add u_add (
        .a_i        (bus.a_dig),
        .b_i        (bus.b_dig),
        .c_in_i     (carry_q),
        .bcd_mode_i (bcd_q),
        .s_c        (sum_c),
        .c_out_c    (c_out_c),
        .err_c      (err_c)
    );

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            bcd_q       <= 1'b0;
            s_dig_q     <= '0;
            s_valid_q   <= 1'b0;
            carry_out_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            bcd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            bcd_q       <= bcd_d;
            s_dig_q     <= s_dig_d;
            s_valid_q   <= s_valid_d;
            carry_out_q <= carry_out_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            bcd_err_q   <= bcd_err_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        bcd_d       = bcd_q;
        s_dig_d     = s_dig_q;
        s_valid_d   = 1'b0;
        carry_out_d = carry_out_q;
        bcd_err_d   = bcd_err_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d   = RUN;
                    bcd_d     = bus.bcd_mode;
                    carry_d   = bus.sub;
                    cnt_d     = '0;
                    bcd_err_d = 1'b0;
                end else begin
                    state_d   = IDLE;
                end
            end
            RUN: begin
                if (bus.dig_valid) begin
                    s_dig_d   = sum_c;
                    s_valid_d = 1'b1;
                    carry_d   = c_out_c;
                    bcd_err_d = bcd_err_q | err_c;
                    if (cnt_q == CNT_W'(NDIG - 1)) begin
                        state_d     = DONE;
                        carry_out_d = c_out_c;
                        cnt_d       = '0;
                    end else begin
                        cnt_d       = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    assign bus.busy      = busy_q;
    assign bus.s_dig     = s_dig_q;
    assign bus.s_valid   = s_valid_q;
    assign bus.carry_out = carry_out_q;
    assign bus.done      = done_q;
    assign bus.bcd_err   = bcd_err_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench for digit_serial_adder: the driver pushes hand-computed
// sum digits, a monitor pops and compares on every s_valid.
module tb_digit_serial_adder;
    import digit_pkg::*;

    localparam int unsigned NDIG = 8;

    typedef struct {
        logic [3:0] dig;
        logic       last;
        logic       cy;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    digit_serial_adder_if bus ();

    digit_serial_adder #(.NDIG(NDIG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compare every presented sum digit against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.s_valid) begin
                    if (q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_s_valid: got s_dig %0h, expected no output at %0t",
                                 bus.s_dig, $time);
                    end else begin
                        e = q.pop_front();
                        chk("s_dig", 32'(bus.s_dig), 32'(e.dig));
                        chk("done", 32'(bus.done), 32'(e.last));
                        if (e.last) begin
                            chk("carry_out", 32'(bus.carry_out), 32'(e.cy));
                            chk("busy_in_done", 32'(bus.busy), 32'd0);
                        end
                    end
                end else if (bus.done) begin
                    chk("done_without_s_valid", 32'(bus.done), 32'd0);
                end
            end
        end
    end

    // One operation; ndig < NDIG leaves the operation unfinished.
    task automatic run_op(input logic bcd, input logic sb,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic cy,
                          input bit gaps, input int ndig);
        logic       err_exp;
        logic [3:0] ad, bd;
        exp_t       e;
        err_exp      = 1'b0;
        bus.start    = 1'b1;
        bus.bcd_mode = bcd;
        bus.sub      = sb;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.bcd_mode = ~bcd;
        bus.sub      = ~sb;
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        chk("bcd_err_cleared", 32'(bus.bcd_err), 32'd0);
        for (int i = 0; i < ndig; i++) begin
            if (gaps && i > 0) begin
                repeat (2) begin
                    bus.dig_valid = 1'b0;
                    bus.a_dig     = 4'hF;
                    bus.b_dig     = 4'hF;
                    @(posedge clk); #1;
                end
            end
            ad = a[4*i +: 4];
            bd = b[4*i +: 4];
            bus.a_dig     = ad;
            bus.b_dig     = bd;
            bus.dig_valid = 1'b1;
            bus.start     = (i == 2);
            e.dig  = res[4*i +: 4];
            e.last = (i == NDIG - 1);
            e.cy   = cy;
            q.push_back(e);
            if (bcd && (ad > 4'd9 || bd > 4'd9)) err_exp = 1'b1;
            @(posedge clk); #1;
            bus.dig_valid = 1'b0;
            bus.start     = 1'b0;
            chk("bcd_err", 32'(bus.bcd_err), 32'(err_exp));
        end
    endtask

    task automatic idle_cycles(input int n);
        bus.dig_valid = 1'b1;
        bus.a_dig     = 4'h9;
        bus.b_dig     = 4'h9;
        repeat (n) begin
            @(posedge clk); #1;
        end
        bus.dig_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_s_dig", 32'(bus.s_dig), 32'd0);
        chk("rst_s_valid", 32'(bus.s_valid), 32'd0);
        chk("rst_carry_out", 32'(bus.carry_out), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_bcd_err", 32'(bus.bcd_err), 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.bcd_mode  = 1'b0;
        bus.sub       = 1'b0;
        bus.a_dig     = '0;
        bus.b_dig     = '0;
        bus.dig_valid = 1'b0;
        #3;
        chk_reset_outputs();
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // dig_valid in IDLE must not produce output
        idle_cycles(3);

        // BCD 45+67 = 112, then back-to-back subtractions
        run_op(1'b1, 1'b0, 32'h00000045, 32'h00000067, 32'h00000112, 1'b0, 1'b0, NDIG);
        run_op(1'b1, 1'b1, 32'h00000045, 32'h99999932, 32'h99999978, 1'b0, 1'b0, NDIG);
        run_op(1'b1, 1'b1, 32'h00000067, 32'h99999954, 32'h00000022, 1'b1, 1'b0, NDIG);
        idle_cycles(2);

        // Binary FFFFFFFF+1 and 3-5
        run_op(1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, NDIG);
        idle_cycles(3);
        chk("carry_out_held", 32'(bus.carry_out), 32'd1);
        run_op(1'b0, 1'b1, 32'h00000003, 32'hFFFFFFFA, 32'hFFFFFFFE, 1'b0, 1'b0, NDIG);

        // Gapped stream gives the same result as the gapless one
        run_op(1'b1, 1'b0, 32'h00000045, 32'h00000067, 32'h00000112, 1'b0, 1'b1, NDIG);

        // Invalid BCD digit 0xA on digit 3: sticky error, deterministic sum
        run_op(1'b1, 1'b0, 32'h0000A000, 32'h00000000, 32'h00010000, 1'b0, 1'b0, NDIG);
        idle_cycles(2);
        chk("bcd_err_held", 32'(bus.bcd_err), 32'd1);

        // Binary op with a carry_out of 1 so the reset check is meaningful
        run_op(1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, NDIG);
        idle_cycles(1);

        // Reset after 4 digits, then redo the full operation
        run_op(1'b0, 1'b0, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0, 4);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(1'b0, 1'b0, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0, NDIG);

        for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("final_busy", 32'(bus.busy), 32'd0);
        chk("final_done", 32'(bus.done), 32'd0);
        chk("final_carry_out", 32'(bus.carry_out), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
